// File: rtl/cache_fill_ctrl.sv
// Instruction-cache line-fill controller: fetches an 8-word line with single-outstanding reads.
// Define CACHE_FILL_CWF_EN to fetch the missed word first (critical-word-first ordering).
module cache_fill_ctrl #(
    parameter int LINE_WORDS = 8
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] PC,
    input  logic        miss,
    output logic        mem_rden,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic [31:0] w0,
    output logic [31:0] w1,
    output logic [31:0] w2,
    output logic [31:0] w3,
    output logic [31:0] w4,
    output logic [31:0] w5,
    output logic [31:0] w6,
    output logic [31:0] w7,
    output logic        update,
    output logic        stall
);

    localparam logic [2:0] LAST_K = 3'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_UPDATE
    } state_t;

    state_t      state;
    logic [2:0]  k;
    logic [26:0] line_tag;
    logic [2:0]  start_off;
    logic [2:0]  miss_start;
    logic [2:0]  slot;
    logic [2:0]  slot_next;
    logic [31:0] words [LINE_WORDS];
    logic        unused_pc;

`ifdef CACHE_FILL_CWF_EN
    assign miss_start = PC[4:2];
    assign unused_pc  = ^PC[1:0];

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            start_off <= 3'd0;
        end else if (state == S_IDLE && miss) begin
            start_off <= PC[4:2];
        end
    end
`else
    assign miss_start = 3'd0;
    assign start_off  = 3'd0;
    assign unused_pc  = ^PC[4:0];
`endif

    // Slot arithmetic wraps in 3 bits so critical-word-first order rolls over the line end.
    assign slot      = start_off + k;
    assign slot_next = start_off + k + 3'd1;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= S_IDLE;
            k        <= 3'd0;
            line_tag <= 27'd0;
            mem_rden <= 1'b0;
            mem_addr <= 32'd0;
            update   <= 1'b0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                words[i] <= 32'd0;
            end
        end else begin
            mem_rden <= 1'b0;
            mem_addr <= 32'd0;
            update   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (miss) begin
                        line_tag <= PC[31:5];
                        k        <= 3'd0;
                        state    <= S_ISSUE;
                        mem_rden <= 1'b1;
                        mem_addr <= {PC[31:5], miss_start, 2'b00};
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Responses are only accepted here; anything arriving elsewhere is dropped.
                    if (mem_rvalid) begin
                        words[slot] <= mem_rdata;
                        if (k == LAST_K) begin
                            state  <= S_UPDATE;
                            update <= 1'b1;
                        end else begin
                            k        <= k + 3'd1;
                            state    <= S_ISSUE;
                            mem_rden <= 1'b1;
                            mem_addr <= {line_tag, slot_next, 2'b00};
                        end
                    end
                end
                S_UPDATE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign w0 = words[0];
    assign w1 = words[1];
    assign w2 = words[2];
    assign w3 = words[3];
    assign w4 = words[4];
    assign w5 = words[5];
    assign w6 = words[6];
    assign w7 = words[7];

    // A miss seen in IDLE stalls immediately, before the FSM has left IDLE.
    assign stall = (state != S_IDLE) | miss;

endmodule
